logic_unit_arbiter: RTL and testbench

Shares one registered bitwise logic unit (AND/OR/XOR/NAND) between `N_REQ` requesters. It grants one requester at a time, round-robin by default. It sequences capture, compute and response through a three-state FSM and returns each result with the id of the requester that issued it. It sits between the lab's per-student stimulus sources and the single shared gate datapath.

---
 rtl/logic_unit_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//
// Shares one registered bitwise logic unit (AND/OR/XOR/NAND) between N_REQ
// requesters. One operation is in flight at a time. Each result is returned
// together with the index of the requester that issued it.
//
// Build option: define LOGIC_ARB_FIXED_PRIO_EN to replace the round-robin
// arbiter with fixed priority, where the lowest index wins. In that build the
// round-robin pointer does not exist. Everything else is identical.
//
// Handshake semantics (request and response sides):
//   A transfer happens on a rising edge where valid and ready are both high.
//   On the request side, req_ready is a one-hot grant offered only in IDLE. It
//   depends combinationally on req_valid and the pointer, never on rsp_ready.
//   A requester that drops req_valid before it is granted is simply skipped,
//   because nothing is queued inside the block.
//   On the response side, rsp_valid stays high in RESP. rsp_data and rsp_id
//   hold stable until an edge with rsp_ready high. Outside RESP, rsp_ready is
//   ignored.
//
// Sequence: accept on edge k (IDLE->EXEC), compute on edge k+1 (EXEC->RESP),
// response visible from then until the consumer takes it.
// Asserting rst aborts any transaction. rst clears every output at once,
// without waiting for a clock edge.

module logic_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*2-1:0]     req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  // Op codes of the shared logic unit
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t state;
  state_t next_state;

  // The arbiter result: winner index and whether any requester is valid
  logic [ID_W-1:0] win;
  logic            found;

  // Strobes decoded by the FSM
  logic            accept;
  logic            load_rsp;

  // Operands latched at accept, so later input changes have no effect
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [ID_W-1:0]  id_q;

  // Packed request buses split per requester, so they can be indexed by win
  logic [WIDTH-1:0] a_arr  [N_REQ];
  logic [WIDTH-1:0] b_arr  [N_REQ];
  logic [1:0]       op_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i]  = req_b[i*WIDTH +: WIDTH];
    assign op_arr[i] = req_op[i*2 +: 2];
  end

  // The shared datapath: a full-width bitwise operation
  function automatic logic [WIDTH-1:0] logic_op(input logic [1:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef LOGIC_ARB_FIXED_PRIO_EN

  // Fixed priority: the lowest-index valid requester wins. The loop scans
  // downward so that the last assignment is the lowest valid index.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[ID_W'(k)]) begin
        win   = ID_W'(k);
        found = 1'b1;
      end
    end
  end

`else

  // Round-robin pointer: the next search starts at the requester after the
  // last winner.
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W:0]   cand;

  // Round-robin search: the first valid bit at or after ptr, with wrap.
  // ptr and k are both below N_REQ, so one conditional subtract wraps cand.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        win   = cand[ID_W-1:0];
        found = 1'b1;
      end
    end
  end

  // Pointer successor of the current winner, modulo N_REQ
  always_comb begin
    ptr_next = '0;
    if (win != ID_W'(N_REQ - 1)) begin
      ptr_next = win + ID_W'(1);
    end
  end

  // Advance the pointer past each accepted requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_next;
    end
  end

`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and grant/strobe decode. Grants are masked by rst so that
  // req_ready stays low for the whole reset.
  always_comb begin
    next_state = state;
    req_ready  = '0;
    accept     = 1'b0;
    load_rsp   = 1'b0;
    case (state)
      IDLE: begin
        if (found && !rst) begin
          req_ready[win] = 1'b1;
          accept         = 1'b1;
          next_state     = EXEC;
        end
      end
      EXEC: begin
        load_rsp   = 1'b1;
        next_state = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Status outputs follow the state directly, so a reset clears them at once
  always_comb begin
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // Capture the winner's operation at accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      id_q <= '0;
    end else if (accept) begin
      a_q  <= a_arr[win];
      b_q  <= b_arr[win];
      op_q <= op_arr[win];
      id_q <= win;
    end
  end

  // Register the result in EXEC. It is then held until the next EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_id   <= '0;
    end else if (load_rsp) begin
      rsp_data <= logic_op(op_q, a_q, b_q);
      rsp_id   <= id_q;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Testbench for logic_unit_arbiter (N_REQ=4, WIDTH=8).
// A transaction-level reference model predicts each cycle's outputs:
// - which requester is granted, given the requests and the pointer;
// - whether a result is outstanding and how many edges old it is;
// - the result value, which is held in an expected queue.
// Directed scenarios come first, then a randomized run.

module tb_logic_unit_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a     = '0;
  logic [N*W-1:0] req_b     = '0;
  logic [N*2-1:0] req_op    = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_data;
  logic [IW-1:0]  rsp_id;
  logic           busy;

  logic_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // ---------------- scoreboard / model state ----------------
  int            total = 0;
  int            bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [IW-1:0] exp_id_q[$];
  int            grant_log[$];
  int            m_ptr  = 0;
  bit            m_busy = 1'b0;
  int            m_age  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Index of the requester that should win now, or -1 if none is valid
  function automatic int model_winner();
`ifdef LOGIC_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (req_valid[k]) return k;
`else
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  function automatic void model_clear();
    m_busy = 1'b0;
    m_ptr  = 0;
    m_age  = 0;
    exp_q.delete();
    exp_id_q.delete();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*2 +: 2] = op;
  endtask

  // One cycle: check the outputs against the model, take the edge, then update the model
  task automatic tick();
    int w;
    logic [N-1:0] exp_ready;
    #1;
    w = model_winner();
    exp_ready = '0;
    if (!m_busy && w >= 0) exp_ready[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 1));
    check("busy", 32'(busy), 32'(m_busy));
    if (m_busy && m_age >= 1) begin
      check("rsp_data", 32'(rsp_data), 32'(exp_q[0]));
      check("rsp_id", 32'(rsp_id), 32'(exp_id_q[0]));
    end
    for (int k = 0; k < N; k++) if (req_ready[k]) grant_log.push_back(k);
    @(posedge clk);
    if (!m_busy) begin
      if (w >= 0) begin
        exp_q.push_back(ref_op(req_op[w*2 +: 2], req_a[w*W +: W], req_b[w*W +: W]));
        exp_id_q.push_back(IW'(w));
        m_ptr  = (w + 1) % N;
        m_busy = 1'b1;
        m_age  = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (rsp_ready) begin
      void'(exp_q.pop_front());
      void'(exp_id_q.pop_front());
      m_busy = 1'b0;
    end
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [7:0] op_exp [4];
  int         exp_rr [5];
  int         exp_sp [2];

  initial begin
    op_exp[0] = 8'h81; op_exp[1] = 8'hE7; op_exp[2] = 8'h66; op_exp[3] = 8'h7E;
`ifdef LOGIC_ARB_FIXED_PRIO_EN
    exp_rr = '{0, 0, 0, 0, 0};
    exp_sp = '{1, 1};
`else
    exp_rr = '{0, 1, 2, 3, 0};
    exp_sp = '{3, 1};
`endif

    // Reset state: the requests are active, but nothing is granted during reset
    req_valid = 4'b1111;
    #3;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '0;
    model_clear();

    // Ops: requester 0, a=C3, b=A5, each op in turn. The operands are scrambled in EXEC.
    for (int op = 0; op < 4; op++) begin
      set_req(0, 8'hC3, 8'hA5, 2'(op));
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      set_req(0, 8'h00, 8'hFF, 2'(3 - op));
      tick();
      check("op_rsp_valid", 32'(rsp_valid), 1);
      check("op_rsp_data", 32'(rsp_data), 32'(op_exp[op]));
      check("op_rsp_id", 32'(rsp_id), 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end

    // Round-robin: all requesters valid, consumer always ready
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h11 * (i + 1)), 8'h3C, 2'(i));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    grant_log.delete();
    repeat (15) tick();
    check("rr_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr_order", grant_log[i], exp_rr[i]);
    drain();

    // Backpressure: requester 1 stays valid while its result waits for 5 cycles
    set_req(1, 8'h9A, 8'h0F, 2'd2);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    tick();
    tick();
    repeat (5) begin
      tick();
      check("bp_req_ready", 32'(req_ready), 0);
      check("bp_rsp_data", 32'(rsp_data), 32'(8'h95));
      check("bp_rsp_id", 32'(rsp_id), 1);
    end
    rsp_ready = 1'b1;
    tick();
    #1 check("bp_regrant", 32'(req_ready), 32'(4'b0010));
    drain();

    // Sparse: ptr is now 2, and requesters 3 and 1 are valid
    grant_log.delete();
    set_req(3, 8'hF0, 8'h0F, 2'd1);
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    repeat (6) tick();
    check("sp_count", grant_log.size(), 2);
    for (int i = 0; i < 2 && i < grant_log.size(); i++) check("sp_order", grant_log[i], exp_sp[i]);
    drain();

    // Reset mid-RESP: the result 5A from requester 2 is aborted
    set_req(2, 8'h5A, 8'hFF, 2'd0);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    tick();
    req_valid = '0;
    tick();
    check("pre_rst_data", 32'(rsp_data), 32'(8'h5A));
    check("pre_rst_id", 32'(rsp_id), 2);
    req_valid = 4'b0110;
    rst = 1'b1;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 0);
    check("arst_rsp_data", 32'(rsp_data), 0);
    check("arst_rsp_id", 32'(rsp_id), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_req_ready", 32'(req_ready), 0);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    grant_log.delete();
    tick();
    check("post_rst_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);
    drain();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom_range(0, 15));
      req_a     = $urandom;
      req_b     = $urandom;
      req_op    = 8'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
